// File: rtl/taus_ctrl.sv
// taus_ctrl: sequencing and arbitration for the three-component 32-bit
// Tausworthe uniform generator. Seeds arrive through a valid/ready handshake,
// are raised to the component minimums, and the generator output is then
// handed out one word per grant to two consumers in round-robin order.
// Optional build macro: TAUS_CTRL_WARMUP_EN adds a WARM state that discards
// WARMUP recurrence steps after every seed load.
module taus_ctrl #(
   parameter int unsigned WARMUP = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_valid,
   output logic        seed_ready,
   input  logic [31:0] seed0,
   input  logic [31:0] seed1,
   input  logic [31:0] seed2,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   output logic [31:0] rnd,
   output logic        running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WARM = 2'd2,
      RUN  = 2'd3
   } state_t;

   state_t      state_reg;
   logic [31:0] s_reg    [3];
   logic [31:0] s_step   [3];
   logic [31:0] seed_in  [3];
   logic [31:0] seed_fix [3];
   logic [31:0] out_word;
   logic [31:0] rnd_reg;
   logic [1:0]  gnt_reg;
   logic [1:0]  pick;
   logic        rr_reg;
   logic        seed_ready_reg;
   logic        running_reg;
   logic        accept;

`ifdef TAUS_CTRL_WARMUP_EN
   logic [15:0] cnt_reg;
`else
   // WARMUP has no effect in this build; the empty block only keeps the
   // parameter referenced so both builds share one interface.
   if (WARMUP == 0) begin : g_warmup_ignored
   end
`endif

   assign seed_in[0] = seed0;
   assign seed_in[1] = seed1;
   assign seed_in[2] = seed2;

   // Per-component recurrence step and seed correction; the three components
   // differ only in mask, shift amounts and minimum legal seed.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_comp
         localparam logic [31:0] MASK = (gi == 0) ? 32'hFFFF_FFFE :
                                        (gi == 1) ? 32'hFFFF_FFF8 : 32'hFFFF_FFF0;
         localparam int SH_A = (gi == 0) ? 12 : (gi == 1) ? 4  : 17;
         localparam int SH_B = (gi == 0) ? 13 : (gi == 1) ? 2  : 3;
         localparam int SH_C = (gi == 0) ? 19 : (gi == 1) ? 25 : 11;
         localparam logic [31:0] MIN_SEED = (gi == 0) ? 32'd2 :
                                            (gi == 1) ? 32'd8 : 32'd16;

         assign s_step[gi] = ((s_reg[gi] & MASK) << SH_A)
                           ^ (((s_reg[gi] << SH_B) ^ s_reg[gi]) >> SH_C);
         assign seed_fix[gi] = (seed_in[gi] < MIN_SEED) ? (seed_in[gi] | MIN_SEED)
                                                        : seed_in[gi];
      end
   endgenerate

   assign out_word = s_step[0] ^ s_step[1] ^ s_step[2];

   // A seed is taken only when the registered ready is high, so the cycle
   // right after reset release never accepts.
   assign accept = seed_valid & seed_ready_reg;

   // Round-robin choice: rr_reg names the consumer that wins a tie.
   always_comb begin
      pick = 2'b00;
      if (req == 2'b11) begin
         pick = rr_reg ? 2'b10 : 2'b01;
      end else if (req[0]) begin
         pick = 2'b01;
      end else if (req[1]) begin
         pick = 2'b10;
      end
   end

   // Controller FSM with registered grant, uniform, ready and running outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         for (int k = 0; k < 3; k++) s_reg[k] <= '0;
         rnd_reg        <= '0;
         gnt_reg        <= '0;
         rr_reg         <= 1'b0;
         seed_ready_reg <= 1'b0;
         running_reg    <= 1'b0;
`ifdef TAUS_CTRL_WARMUP_EN
         cnt_reg        <= '0;
`endif
      end else begin
         // Defaults: grants are single-cycle pulses, flags track the state.
         gnt_reg        <= 2'b00;
         seed_ready_reg <= (state_reg == IDLE) || (state_reg == RUN);
         running_reg    <= (state_reg == RUN);
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  for (int k = 0; k < 3; k++) s_reg[k] <= seed_fix[k];
                  state_reg      <= LOAD;
                  seed_ready_reg <= 1'b0;
               end
            end
            LOAD: begin
`ifdef TAUS_CTRL_WARMUP_EN
               cnt_reg        <= 16'(WARMUP);
               state_reg      <= WARM;
               seed_ready_reg <= 1'b0;
`else
               state_reg      <= RUN;
               seed_ready_reg <= 1'b1;
               running_reg    <= 1'b1;
`endif
            end
`ifdef TAUS_CTRL_WARMUP_EN
            WARM: begin
               for (int k = 0; k < 3; k++) s_reg[k] <= s_step[k];
               cnt_reg <= cnt_reg - 16'd1;
               if (cnt_reg <= 16'd1) begin
                  state_reg      <= RUN;
                  seed_ready_reg <= 1'b1;
                  running_reg    <= 1'b1;
               end else begin
                  seed_ready_reg <= 1'b0;
               end
            end
`endif
            RUN: begin
               if (accept) begin
                  // A new seed wins over any request this cycle.
                  for (int k = 0; k < 3; k++) s_reg[k] <= seed_fix[k];
                  state_reg      <= LOAD;
                  seed_ready_reg <= 1'b0;
                  running_reg    <= 1'b0;
               end else if (|req) begin
                  for (int k = 0; k < 3; k++) s_reg[k] <= s_step[k];
                  rnd_reg <= out_word;
                  gnt_reg <= pick;
                  rr_reg  <= pick[0];
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign seed_ready = seed_ready_reg;
   assign gnt        = gnt_reg;
   assign rnd        = rnd_reg;
   assign running    = running_reg;

endmodule

// File: tb/tb_taus_ctrl.sv
// tb_taus_ctrl: self-checking bench for taus_ctrl. A cycle-level behavioural
// model (seed load computed in one go, a busy countdown, arithmetic recurrence)
// predicts every output; a negedge compare process checks it each cycle, and
// a few literal values pin the model and the directed scenarios.
module tb_taus_ctrl;

`ifdef TAUS_CTRL_WARMUP_EN
   localparam int W = 2;
`else
   localparam int W = 0;
`endif

   logic        clk;
   logic        rst;
   logic        seed_valid;
   logic        seed_ready;
   logic [31:0] seed0, seed1, seed2;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [31:0] rnd;
   logic        running;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   taus_ctrl #(.WARMUP(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .seed0      (seed0),
      .seed1      (seed1),
      .seed2      (seed2),
      .req        (req),
      .gnt        (gnt),
      .rnd        (rnd),
      .running    (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] comp(input logic [31:0] x, input logic [31:0] mask,
                                        input int a, input int b, input int c);
      longint unsigned two32, t1, t2;
      two32 = 64'h1_0000_0000;
      t1 = ((64'(x & mask)) * (64'd1 << a)) % two32;
      t2 = ((((64'(x)) * (64'd1 << b)) % two32) ^ 64'(x)) / (64'd1 << c);
      return 32'(t1 ^ t2);
   endfunction

   function automatic logic [95:0] adv(input logic [95:0] s);
      return {comp(s[95:64], 32'hFFFF_FFFE, 12, 13, 19),
              comp(s[63:32], 32'hFFFF_FFF8, 4, 2, 25),
              comp(s[31:0],  32'hFFFF_FFF0, 17, 3, 11)};
   endfunction

   function automatic logic [31:0] outof(input logic [95:0] s);
      return s[95:64] ^ s[63:32] ^ s[31:0];
   endfunction

   function automatic logic [31:0] fix(input logic [31:0] x, input logic [31:0] lo);
      return (x < lo) ? (x | lo) : x;
   endfunction

   logic [95:0] m_s = '0;
   int          m_busy = 0;
   int          m_rr = 0;
   int          m_who = 0;
   bit          m_seeded = 0;
   bit          m_acc = 0;
   logic [1:0]  e_gnt = 2'b00;
   logic [31:0] e_rnd = '0;
   logic        e_ready = 1'b0;
   logic        e_running = 1'b0;
   int          cyc = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_s = '0; m_busy = 0; m_rr = 0; m_seeded = 0;
         e_gnt = 2'b00; e_rnd = '0; e_ready = 1'b0; e_running = 1'b0;
      end else begin
         cyc++;
         m_acc = seed_valid && e_ready;
         e_gnt = 2'b00;
         if (m_acc) begin
            m_s = {fix(seed0, 32'd2), fix(seed1, 32'd8), fix(seed2, 32'd16)};
            for (int k = 0; k < W; k++) m_s = adv(m_s);
            m_busy   = 1 + W;
            m_seeded = 1;
            $display("seed  cyc=%0d s0=%h s1=%h s2=%h", cyc, seed0, seed1, seed2);
         end else if (m_busy > 0) begin
            m_busy--;
         end else if (m_seeded && req != 2'b00) begin
            if (req == 2'b11) m_who = m_rr;
            else              m_who = req[0] ? 0 : 1;
            m_s   = adv(m_s);
            e_rnd = outof(m_s);
            e_gnt = (m_who == 0) ? 2'b01 : 2'b10;
            m_rr  = 1 - m_who;
            $display("grant cyc=%0d gnt=%b rnd=%h", cyc, e_gnt, e_rnd);
         end
         e_ready   = (m_busy == 0);
         e_running = m_seeded && (m_busy == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("gnt",        32'(gnt),        32'(e_gnt));
         check("rnd",        rnd,             e_rnd);
         check("running",    32'(running),    32'(e_running));
         check("seed_ready", 32'(seed_ready), 32'(e_ready));
         check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      end
   end

   task automatic wait_gnt(input string name);
      int n;
      n = 0;
      while (gnt == 2'b00 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (gnt == 2'b00) begin
         errors++;
         checks++;
         $display("FAIL %s actual=no_grant required=grant_within_40_cycles", name);
      end
   endtask

   task automatic async_reset_check();
      #2 rst = 1'b0;
      #1;
      check("rst_gnt",     32'(gnt),     32'd0);
      check("rst_rnd",     rnd,          32'd0);
      check("rst_running", 32'(running), 32'd0);
   endtask

   logic [95:0] pin;

   initial begin
      rst = 1'b0; seed_valid = 1'b0; req = 2'b00;
      seed0 = '0; seed1 = '0; seed2 = '0;

      // Pin the model to hand-derived recurrence values.
      pin = {32'd2, 32'd8, 32'd16};
      pin = adv(pin);
      check("model_out1", outof(pin), 32'h0020_2080);
      pin = adv(pin);
      check("model_out2", outof(pin), 32'h0200_2C80);

      repeat (3) @(negedge clk);
      chk_en = 1;
      check("reset_ready",   32'(seed_ready), 32'd0);
      check("reset_rnd",     rnd,             32'd0);
      check("reset_running", 32'(running),    32'd0);
      rst = 1'b1;

      // Idle with requests: nothing granted.
      req = 2'b11;
      repeat (4) @(negedge clk);
      check("idle_no_gnt", 32'(gnt), 32'd0);

      // Seed 0/0/0 with both consumers requesting.
      seed_valid = 1'b1;
      @(negedge clk);
      seed_valid = 1'b0;
      wait_gnt("first_grant_dual");
`ifndef TAUS_CTRL_WARMUP_EN
      check("dual_g1", 32'(gnt), 32'd1);
      check("dual_r1", rnd, 32'h0020_2080);
      @(negedge clk);
      check("dual_g2", 32'(gnt), 32'd2);
      check("dual_r2", rnd, 32'h0200_2C80);
      @(negedge clk);
      check("dual_g3", 32'(gnt), 32'd1);
`endif
      repeat (4) @(negedge clk);

      // Reseed in RUN with a request on the same edge: no grant that cycle.
      req = 2'b01;
      seed_valid = 1'b1;
      @(negedge clk);
      seed_valid = 1'b0;
      check("preempt_no_gnt", 32'(gnt), 32'd0);
      wait_gnt("first_grant_single");
`ifndef TAUS_CTRL_WARMUP_EN
      check("single_g1", 32'(gnt), 32'd1);
      check("single_r1", rnd, 32'h0020_2080);
      @(negedge clk);
      check("single_g2", 32'(gnt), 32'd1);
      check("single_r2", rnd, 32'h0200_2C80);
`endif
      repeat (3) @(negedge clk);

      // seed_valid held across LOAD: only re-accepted once back in RUN.
      seed0 = 32'd5; seed1 = 32'd7; seed2 = 32'd100;
      seed_valid = 1'b1;
      @(negedge clk);
      check("load_not_ready", 32'(seed_ready), 32'd0);
      repeat (2 + W) @(negedge clk);
      seed_valid = 1'b0;
      repeat (5) @(negedge clk);

      // Asynchronous reset mid-RUN, then requests without a seed.
      async_reset_check();
      @(negedge clk);
      rst = 1'b1;
      req = 2'b11;
      repeat (5) @(negedge clk);
      check("post_rst_no_gnt", 32'(gnt), 32'd0);
      seed0 = 32'h1234_5678; seed1 = 32'd3; seed2 = 32'hDEAD_BEEF;
      seed_valid = 1'b1;
      @(negedge clk);
      seed_valid = 1'b0;
      repeat (6) @(negedge clk);

      // Randomized phase.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req        = 2'($urandom_range(0, 3));
         seed_valid = ($urandom_range(0, 49) == 0);
         seed0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
         seed1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
         seed2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
         if ($urandom_range(0, 399) == 0) begin
            async_reset_check();
            @(negedge clk);
            rst = 1'b1;
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/taus_ctrl.md
# taus_ctrl

Sequencing and arbitration controller for the 32-bit three-component Tausworthe uniform generator in the AWGN chain. It owns the three generator state words and accepts seeds through a handshake. It corrects seeds that are below the component minimums, optionally discards a warm-up run, and then shares the output stream between two consumers (Box-Muller u0/u1 paths) with round-robin grants. The consumers receive one fresh 32-bit uniform per grant.

## Interface
- `WARMUP`, 16 — recurrence steps discarded after each seed load (1..65535); used only with `TAUS_CTRL_WARMUP_EN`.
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `seed_valid` in 1 — seed triple offered.
- `seed_ready` out 1 — controller can accept a seed.
- `seed0`, `seed1`, `seed2` in 32 each — seed words for components s0/s1/s2.
- `req` in 2 — `req[i]` means consumer i wants one uniform; level, sampled every cycle.
- `gnt` out 2 — one-hot or zero, registered; `gnt[i]` for one cycle means `rnd` is for consumer i.
- `rnd` out 32 — registered uniform output; holds its value between grants.
- `running` out 1 — high in RUN.

## Operation
- Reset values: FSM=IDLE; s0=s1=s2=0; `rnd`=0; `gnt`=0; `running`=0; `seed_ready`=0 during reset, then follows the state; RR pointer=0 (consumer 0 has priority).
- Recurrence, one step, all 32-bit with truncation after every shift:
  - s0' = ((s0 & FFFFFFFE)<<12) ^ (((s0<<13)^s0)>>19)
  - s1' = ((s1 & FFFFFFF8)<<4) ^ (((s1<<2)^s1)>>25)
  - s2' = ((s2 & FFFFFFF0)<<17) ^ (((s2<<3)^s2)>>11)
  - out = s0'^s1'^s2'
- Seed correction, applied on load: if seed0<2, OR in 2; if seed1<8, OR in 8; if seed2<16, OR in 16. Other values load unchanged.
- `seed_ready` = 1 in IDLE and RUN, 0 in LOAD and WARM.
- FSM states and transitions:
  - IDLE: no grants. Seed accept goes to LOAD.
  - LOAD, 1 cycle: the corrected seeds are written into s0..s2. Next state is WARM if the macro is defined, else RUN.
  - WARM: one step per cycle, output discarded, down-counter from WARMUP. Go to RUN after the WARMUP-th step. No grants.
  - RUN: if any `req` bit is set, take one step, write `rnd`<=out, and pulse the chosen `gnt` bit. With no request the state holds and `gnt`=0.
- Arbitration:
  - Both requesting: grant the consumer named by the pointer, then point the pointer at the other consumer.
  - Single requester: grant it, and point the pointer at the other consumer.
- Seed accept in RUN preempts that cycle's grant: `gnt`=0 and the FSM goes to LOAD. The old state is discarded.
- Reset mid-WARM or mid-RUN aborts immediately to reset values. The FSM needs a new seed before any further grant.

## Timing
- Seed handshake completes on the edge where `seed_valid` & `seed_ready`.
- Seed accept at edge E:
  - LOAD during cycle E..E+1.
  - Without warm-up, RUN from edge E+1; the first grant can appear at E+2.
  - With warm-up, RUN from edge E+1+WARMUP.
- Grant latency: a `req` sampled at edge T in RUN gives `gnt` and `rnd` valid after edge T, for one cycle.
- Throughput: one grant per cycle. A consumer holding `req` continuously, with no competitor, gets one grant per cycle.
- `gnt` never has 2 bits set. No grant appears outside RUN.

## Configuration
- `TAUS_CTRL_WARMUP_EN` defined:
  - The WARM state, counter and `WARMUP` parameter are compiled in.
  - Every seed load is followed by WARMUP discarded steps.
- Not defined:
  - LOAD goes directly to RUN.
  - The counter logic is absent, and `WARMUP` is ignored.

## Test plan
- Reset, then seed 0/0/0 (corrected to 2/8/16), macro off, `req`=01 held: first `rnd`=0x00202080 with `gnt`=01; the next cycle gives `rnd`=0x02002C80.
- `req`=11 held in RUN: `gnt` alternates 01,10,01,10. The `rnd` sequence equals the single-consumer sequence from the same seed.
- Macro on, WARMUP=2, seed 2/8/16: `gnt` stays 0 for 3 cycles after accept. The first granted `rnd` equals the 3rd output of the off-macro sequence.
- `seed_valid` with `req`=01 in RUN on the same edge: no grant that cycle. After reload, the output sequence restarts from the new seed.
- Assert `rst` low mid-RUN: `gnt`, `rnd`, `running` = 0 asynchronously. No grant appears with `req`=11 until a new seed is loaded.
- `seed_valid` held during LOAD/WARM: `seed_ready`=0 and no second load. The seed is accepted only once the FSM is in RUN.
